mem_preload_ctrl: RTL

//  Synthesizable, parametrised successor to bench-side memory override: preloads a
//  RAM region from a valid/ready word stream while holding the CPU core off the bus.

---
 rtl/mem_preload_pkg.sv | 24 ++
 rtl/mem_preload_csum.sv | 40 ++++
 rtl/mem_preload_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_preload_pkg.sv
// mem_preload_pkg: shared state type, default widths and checksum helper for the
// memory preload controller.
package mem_preload_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefAddrWidth = 16;
    localparam int unsigned DefDepth     = 65536;
    localparam int unsigned DefCsumWidth = 16;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StVerify,
        StDone,
        StError
    } state_e;

    // Plain modular add; callers truncate the result to their accumulator width.
    function automatic logic [31:0] csum_add(input logic [31:0] acc, input logic [31:0] data);
        return acc + data;
    endfunction

endpackage

// File: rtl/mem_preload_csum.sv
// mem_preload_csum: checksum accumulator with synchronous clear and enable.
// Widths up to 32 bits.
module mem_preload_csum
    import mem_preload_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned CSUM_WIDTH = DefCsumWidth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [CSUM_WIDTH-1:0] sum
);

    logic [CSUM_WIDTH-1:0] sum_q, sum_d;

    // Next sum: clear wins over accumulate.
    always_comb begin
        sum_d = sum_q;
        if (clr) begin
            sum_d = '0;
        end else if (en) begin
            sum_d = CSUM_WIDTH'(csum_add(32'(sum_q), 32'(data)));
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum = sum_q;

endmodule

// File: rtl/mem_preload_ctrl.sv
// mem_preload_ctrl: preloads a RAM region from a valid/ready word stream while
// holding the CPU off the bus. Addresses wrap modulo DEPTH.
// Define MEM_PRELOAD_VERIFY_EN to add a readback pass that re-sums the region and
// flags a checksum mismatch.
module mem_preload_ctrl
    import mem_preload_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned ADDR_WIDTH = DefAddrWidth,
    parameter int unsigned DEPTH      = DefDepth,
    parameter int unsigned CSUM_WIDTH = DefCsumWidth
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  mem_we,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  cpu_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_done,
    output logic [CSUM_WIDTH-1:0] csum
);

    function automatic logic [ADDR_WIDTH-1:0] wrap_inc(input logic [ADDR_WIDTH-1:0] a);
        if (32'(a) == DEPTH - 1) begin
            return '0;
        end
        return a + ADDR_WIDTH'(1);
    endfunction

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [ADDR_WIDTH:0]   words_done_q, words_done_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  mem_we_q, mem_we_d;
    logic                  done_q, done_d;
    logic                  busy_w, xfer, start_ok;
    logic [CSUM_WIDTH-1:0] load_sum;

    assign busy_w   = state_q inside {StLoad, StFlush, StVerify};
    assign s_ready  = (state_q == StLoad);
    assign xfer     = s_valid & s_ready;
    assign start_ok = start & ~abort & (state_q inside {StIdle, StDone, StError});

    mem_preload_csum #(
        .DATA_WIDTH(DATA_WIDTH),
        .CSUM_WIDTH(CSUM_WIDTH)
    ) u_load_csum (
        .clk  (clk),
        .reset(reset),
        .clr  (start_ok),
        .en   (xfer),
        .data (s_data),
        .sum  (load_sum)
    );

`ifdef MEM_PRELOAD_VERIFY_EN
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH:0]   rd_cnt_q, rd_cnt_d;
    logic                  mem_re_q, mem_re_d;
    logic                  rd_valid_q;
    logic                  error_q, error_d;
    logic [CSUM_WIDTH-1:0] verify_sum;
    logic                  verify_match;

    // Read data arrives the cycle after each mem_re.
    mem_preload_csum #(
        .DATA_WIDTH(DATA_WIDTH),
        .CSUM_WIDTH(CSUM_WIDTH)
    ) u_verify_csum (
        .clk  (clk),
        .reset(reset),
        .clr  (start_ok | (state_q == StFlush)),
        .en   (rd_valid_q & (state_q == StVerify)),
        .data (mem_rdata),
        .sum  (verify_sum)
    );

    // The last read word is folded in combinationally so the decision lands on its cycle.
    assign verify_match =
        (CSUM_WIDTH'(csum_add(32'(verify_sum), 32'(mem_rdata))) == load_sum);
`else
    logic unused_rdata;
    assign unused_rdata = ^mem_rdata;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        len_d        = len_q;
        words_done_d = words_done_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_we_d     = 1'b0;
        done_d       = done_q;
`ifdef MEM_PRELOAD_VERIFY_EN
        base_d       = base_q;
        rd_cnt_d     = rd_cnt_q;
        mem_re_d     = 1'b0;
        error_d      = error_q;
`endif
        // An accepted word is always written, even if abort lands on the same edge.
        if (xfer) begin
            mem_we_d     = 1'b1;
            mem_addr_d   = ptr_q;
            mem_wdata_d  = s_data;
            ptr_d        = wrap_inc(ptr_q);
            words_done_d = words_done_q + 1'b1;
        end

        if (abort) begin
            state_d = StIdle;
        end else if (start_ok) begin
            ptr_d        = start_addr;
            len_d        = length;
            words_done_d = '0;
`ifdef MEM_PRELOAD_VERIFY_EN
            base_d       = start_addr;
            error_d      = 1'b0;
`endif
            if (length == '0) begin
                state_d = StDone;
                done_d  = 1'b1;
            end else begin
                state_d = StLoad;
                done_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (xfer && (words_done_q + 1'b1 == len_q)) begin
                        state_d = StFlush;
                    end
                end
                StFlush: begin
`ifdef MEM_PRELOAD_VERIFY_EN
                    // Issue the first readback while the final write retires.
                    state_d    = StVerify;
                    mem_re_d   = 1'b1;
                    mem_addr_d = base_q;
                    ptr_d      = wrap_inc(base_q);
                    rd_cnt_d   = (ADDR_WIDTH + 1)'(1);
`else
                    state_d = StDone;
                    done_d  = 1'b1;
`endif
                end
`ifdef MEM_PRELOAD_VERIFY_EN
                StVerify: begin
                    if (rd_cnt_q != len_q) begin
                        mem_re_d   = 1'b1;
                        mem_addr_d = ptr_q;
                        ptr_d      = wrap_inc(ptr_q);
                        rd_cnt_d   = rd_cnt_q + 1'b1;
                    end
                    // Reads are back to back, so valid data with no read in flight is the last.
                    if (rd_valid_q && !mem_re_q) begin
                        if (verify_match) begin
                            state_d = StDone;
                            done_d  = 1'b1;
                        end else begin
                            state_d = StError;
                            error_d = 1'b1;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            len_q        <= '0;
            words_done_q <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_we_q     <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            len_q        <= len_d;
            words_done_q <= words_done_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_we_q     <= mem_we_d;
            done_q       <= done_d;
        end
    end

`ifdef MEM_PRELOAD_VERIFY_EN
    // Readback registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base_q     <= '0;
            rd_cnt_q   <= '0;
            mem_re_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            base_q     <= base_d;
            rd_cnt_q   <= rd_cnt_d;
            mem_re_q   <= mem_re_d;
            rd_valid_q <= mem_re_q;
            error_q    <= error_d;
        end
    end

    assign mem_re = mem_re_q;
    assign error  = error_q;
`else
    assign mem_re = 1'b0;
    assign error  = 1'b0;
`endif

    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign done       = done_q;
    assign busy       = busy_w;
    assign cpu_hold   = busy_w;
    assign words_done = words_done_q;
    assign csum       = load_sum;

endmodule
